// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file geometry and writeback payload types for the writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN     = 16;
    localparam int unsigned REG_AW   = 3;
    localparam int unsigned NUM_REGS = 8;
    localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   dat;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: marks destinations in flight at issue, clears them at commit,
// and stalls issue on any RAW/WAW hazard against a busy register.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_rd,
    input  logic [REG_AW-1:0]   iss_rs1,
    input  logic [REG_AW-1:0]   iss_rs2,
    input  logic [REG_AW-1:0]   commit_rd,
    output logic                iss_stall,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                iss_fire;

    always_comb begin
        iss_stall = 1'b1;
        if (rst_n) begin
            iss_stall = iss_valid && (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd]);
        end
        iss_fire = iss_valid && !iss_stall && (iss_rd != REG_ZERO);
    end

    // Clear before set so a same-cycle set of the committing register wins.
    always_comb begin
        busy_d = busy_q;
        if (commit_rd != REG_ZERO) begin
            busy_d[commit_rd] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between ALU (A) and load unit (B): sole driver of the register
// file write port, with a starvation counter that lets A win after STARVE_MAX refusals.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [REG_AW-1:0]   a_rd,
    input  logic [XLEN-1:0]     a_dat,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [REG_AW-1:0]   b_rd,
    input  logic [XLEN-1:0]     b_dat,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_rd,
    input  logic [REG_AW-1:0]   iss_rs1,
    input  logic [REG_AW-1:0]   iss_rs2,
    output logic                iss_stall,
    output logic [REG_AW-1:0]   rf_tgt,
    output logic [XLEN-1:0]     rf_tgt_dat,
    output logic [NUM_REGS-1:0] busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    wb_req_t          wb_q;
    wb_req_t          wb_d;
    gnt_e             gnt;

    // B has priority unless A has been refused STARVE_MAX times in a row.
    always_comb begin
        gnt = GNT_NONE;
        if (rst_n) begin
            if (a_valid && (!b_valid || (starve_q == STARVE_LIM))) begin
                gnt = GNT_A;
            end else if (b_valid) begin
                gnt = GNT_B;
            end
        end
        a_ready = (gnt == GNT_A);
        b_ready = (gnt == GNT_B);
    end

    always_comb begin
        wb_d     = '0;
        starve_d = starve_q;
        case (gnt)
            GNT_A:   wb_d = '{rd: a_rd, dat: a_dat};
            GNT_B:   wb_d = '{rd: b_rd, dat: b_dat};
            default: wb_d = '0;
        endcase
        if (wb_d.rd == REG_ZERO) begin
            wb_d.dat = '0;
        end
        if (a_valid) begin
            if (gnt == GNT_A) begin
                starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q     <= '0;
            starve_q <= '0;
        end else begin
            wb_q     <= wb_d;
            starve_q <= starve_d;
        end
    end

    assign rf_tgt     = wb_q.rd;
    assign rf_tgt_dat = wb_q.dat;

    regfile_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .commit_rd (wb_q.rd),
        .iss_stall (iss_stall),
        .busy      (busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model on the write port.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, a_ready;
    logic [2:0]  a_rd;
    logic [15:0] a_dat;
    logic        b_valid, b_ready;
    logic [2:0]  b_rd;
    logic [15:0] b_dat;
    logic        iss_valid;
    logic [2:0]  iss_rd, iss_rs1, iss_rs2;
    logic        iss_stall;
    logic [2:0]  rf_tgt;
    logic [15:0] rf_tgt_dat;
    logic [7:0]  busy;

    logic [15:0] rf_mem [8];

    int total;
    int bad;

    regfile_wb_arbiter #(.STARVE_MAX(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_rd       (a_rd),
        .a_dat      (a_dat),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_rd       (b_rd),
        .b_dat      (b_dat),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_stall  (iss_stall),
        .rf_tgt     (rf_tgt),
        .rf_tgt_dat (rf_tgt_dat),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file written every posedge; x0 never stored.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'h0;
        end else if (rf_tgt != 3'd0) begin
            rf_mem[rf_tgt] <= rf_tgt_dat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_rd = 0; a_dat = 0;
        b_valid = 0; b_rd = 0; b_dat = 0;
        iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        a_valid = 1; a_rd = 3'd1; iss_valid = 1;
        #1;
        total++;
        if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
        total++;
        if (iss_stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b exp=1", iss_stall); end
        idle_inputs();
        tick();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (rf_tgt !== 3'd0 || rf_tgt_dat !== 16'h0 || busy !== 8'h0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                bad++;
                $display("FAIL idle_state cyc=%0d tgt=%0d dat=%h busy=%h ar=%b br=%b exp all 0",
                         i, rf_tgt, rf_tgt_dat, busy, a_ready, b_ready);
            end
        end
    endtask

    task automatic test_single_a();
        a_valid = 1; a_rd = 3'd3; a_dat = 16'h1234;
        #1;
        total++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            bad++; $display("FAIL single_a_ready got a=%b b=%b exp a=1 b=0", a_ready, b_ready);
        end
        tick();
        idle_inputs();
        total++;
        if (rf_tgt !== 3'd3 || rf_tgt_dat !== 16'h1234) begin
            bad++; $display("FAIL single_a_out got %0d/%h exp 3/1234", rf_tgt, rf_tgt_dat);
        end
        tick();
        total++;
        if (rf_mem[3] !== 16'h1234) begin bad++; $display("FAIL rf_x3 got=%h exp=1234", rf_mem[3]); end
        total++;
        if (rf_tgt !== 3'd0) begin bad++; $display("FAIL single_a_idle got=%0d exp=0", rf_tgt); end
    endtask

    task automatic test_arbitration();
        logic [5:0] exp_a;
        exp_a = 6'b001000;
        a_valid = 1; a_rd = 3'd1; a_dat = 16'hAAAA;
        b_valid = 1; b_rd = 3'd6; b_dat = 16'hBBBB;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (a_ready !== exp_a[i] || b_ready !== !exp_a[i]) begin
                bad++; $display("FAIL arb_grant cyc=%0d got a=%b b=%b exp a=%b", i, a_ready, b_ready, exp_a[i]);
            end
            tick();
            total++;
            if (rf_tgt !== (exp_a[i] ? 3'd1 : 3'd6) || rf_tgt_dat !== (exp_a[i] ? 16'hAAAA : 16'hBBBB)) begin
                bad++; $display("FAIL arb_out cyc=%0d got %0d/%h", i, rf_tgt, rf_tgt_dat);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        a_valid = 1; a_rd = 3'd4; a_dat = 16'h0404;
        tick();
        a_valid = 0; b_valid = 1; b_rd = 3'd7; b_dat = 16'h0707;
        #1;
        total++;
        if (rf_tgt !== 3'd4 || rf_tgt_dat !== 16'h0404 || b_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_first got %0d/%h br=%b exp 4/0404 br=1", rf_tgt, rf_tgt_dat, b_ready);
        end
        tick();
        idle_inputs();
        total++;
        if (rf_tgt !== 3'd7 || rf_tgt_dat !== 16'h0707) begin
            bad++; $display("FAIL b2b_second got %0d/%h exp 7/0707", rf_tgt, rf_tgt_dat);
        end
        tick();
    endtask

    task automatic test_raw_stall();
        iss_valid = 1; iss_rd = 3'd5;
        #1;
        total++;
        if (iss_stall !== 1'b0) begin bad++; $display("FAIL raw_issue_rd5 got=%b exp=0", iss_stall); end
        tick();
        iss_rd = 3'd0; iss_rs1 = 3'd5;
        #1;
        total++;
        if (iss_stall !== 1'b1 || busy !== 8'h20) begin
            bad++; $display("FAIL raw_stall got stall=%b busy=%h exp 1/20", iss_stall, busy);
        end
        a_valid = 1; a_rd = 3'd5; a_dat = 16'h5555;
        #1;
        tick();
        a_valid = 0;
        #1;
        total++;
        if (iss_stall !== 1'b1 || rf_tgt !== 3'd5) begin
            bad++; $display("FAIL raw_commit_cycle got stall=%b tgt=%0d exp 1/5", iss_stall, rf_tgt);
        end
        tick();
        total++;
        if (iss_stall !== 1'b0 || busy !== 8'h00) begin
            bad++; $display("FAIL raw_release got stall=%b busy=%h exp 0/00", iss_stall, busy);
        end
        tick();
        idle_inputs();
        total++;
        if (rf_mem[5] !== 16'h5555) begin bad++; $display("FAIL rf_x5 got=%h exp=5555", rf_mem[5]); end
    endtask

    task automatic test_x0();
        iss_valid = 1; iss_rd = 3'd0;
        #1;
        total++;
        if (iss_stall !== 1'b0) begin bad++; $display("FAIL x0_issue got=%b exp=0", iss_stall); end
        tick();
        iss_valid = 0;
        a_valid = 1; a_rd = 3'd0; a_dat = 16'hFFFF;
        #1;
        total++;
        if (a_ready !== 1'b1 || busy !== 8'h00) begin
            bad++; $display("FAIL x0_accept got ar=%b busy=%h exp 1/00", a_ready, busy);
        end
        tick();
        idle_inputs();
        total++;
        if (rf_tgt !== 3'd0 || rf_tgt_dat !== 16'h0 || busy !== 8'h00) begin
            bad++; $display("FAIL x0_out got %0d/%h busy=%h exp 0/0000/00", rf_tgt, rf_tgt_dat, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        iss_valid = 1; iss_rd = 3'd2;
        a_valid = 1; a_rd = 3'd2; a_dat = 16'h2222;
        #1;
        total++;
        if (iss_stall !== 1'b0 || a_ready !== 1'b1) begin
            bad++; $display("FAIL mid_issue got stall=%b ar=%b exp 0/1", iss_stall, a_ready);
        end
        tick();
        idle_inputs();
        total++;
        if (busy !== 8'h04 || rf_tgt !== 3'd2) begin
            bad++; $display("FAIL mid_pending got busy=%h tgt=%0d exp 04/2", busy, rf_tgt);
        end
        rst_n = 0;
        iss_valid = 1; iss_rs1 = 3'd2;
        #1;
        total++;
        if (iss_stall !== 1'b1) begin bad++; $display("FAIL mid_rst_stall got=%b exp=1", iss_stall); end
        tick();
        rst_n = 1;
        #1;
        total++;
        if (busy !== 8'h00 || rf_tgt !== 3'd0 || rf_tgt_dat !== 16'h0 || iss_stall !== 1'b0) begin
            bad++; $display("FAIL mid_after_rst got busy=%h tgt=%0d dat=%h stall=%b exp 00/0/0000/0",
                            busy, rf_tgt, rf_tgt_dat, iss_stall);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single_a();
        test_arbitration();
        test_back_to_back();
        test_raw_stall();
        test_x0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
